// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one i2c controller between NUM_REQ requesters,
// with a one-cycle command issue, completion wait, timeout guard and registered ack/rdata.
module i2c_req_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 6,
  parameter int TIMEOUT   = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_rd,
  input  logic [NUM_REQ*ADDRWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATAWIDTH-1:0]           rdata,
  output logic                           timeout_err,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           wr_en,
  output logic                           rd_en,
  output logic [ADDRWIDTH-1:0]           addr,
  output logic [DATAWIDTH-1:0]           data,
  input  logic                           ctrl_done,
  input  logic [DATAWIDTH-1:0]           ctrl_rdata
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, g, win;
  logic [TW-1:0] timer;
  logic rd, w_rd;
  logic [ADDRWIDTH-1:0] w_addr;
  logic [DATAWIDTH-1:0] w_data;
  // Pass 0 covers indices below rr_ptr, pass 1 those at/above it; the last hit wins,
  // so the lowest requesting index at/above rr_ptr beats any wrapped-around one.
  always_comb begin
    win = '0;
    w_rd = 1'b0;
    w_addr = '0;
    w_data = '0;
    for (int p = 0; p < 2; p++)
      for (int k = NUM_REQ - 1; k >= 0; k--)
        if (req[k] && ((IW'(k) >= rr_ptr) == (p == 1))) begin
          win = IW'(k);
          w_rd = req_rd[k];
          w_addr = req_addr[k*ADDRWIDTH +: ADDRWIDTH];
          w_data = req_data[k*DATAWIDTH +: DATAWIDTH];
        end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      timer <= '0;
      g <= '0;
      rd <= 1'b0;
      ack <= '0;
      grant <= '0;
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      timeout_err <= 1'b0;
      addr <= '0;
      data <= '0;
      rdata <= '0;
    end else begin
      ack <= '0;
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          g <= win;
          rd <= w_rd;
          addr <= w_addr;
          data <= w_data;
          grant <= NUM_REQ'(1) << win;
          state <= ISSUE;
        end
        ISSUE: begin
          rd_en <= rd;
          wr_en <= !rd;
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (ctrl_done) begin
            if (rd) rdata <= ctrl_rdata;
            timeout_err <= 1'b0;
            ack <= grant;
            state <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            rdata <= '0;
            ack <= grant;
            state <= RESP;
          end
        end
        RESP: begin
          grant <= '0;
          timeout_err <= 1'b0;
          rr_ptr <= (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: directed and random stimulus against a cycle-offset transaction model
// of the arbiter, plus literal expectations for the documented scenarios.
module tb_i2c_req_arbiter;
  localparam int NR = 4, AW = 6, DW = 8, TO = 256, AB = NR * AW;
  logic clk = 0, reset = 0;
  logic [NR-1:0] req = '0, req_rd = '0;
  logic [AB-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0] ack, grant;
  logic [DW-1:0] rdata, data, ctrl_rdata = '0;
  logic [AW-1:0] addr;
  logic timeout_err, wr_en, rd_en, ctrl_done;
  logic man_done = 0, auto_done = 0;
  assign ctrl_done = man_done | auto_done;
  always #5 clk = ~clk;

  i2c_req_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_rd(req_rd), .req_addr(req_addr),
    .req_data(req_data), .ack(ack), .rdata(rdata), .timeout_err(timeout_err),
    .grant(grant), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .data(data),
    .ctrl_done(ctrl_done), .ctrl_rdata(ctrl_rdata)
  );

  int vec = 0, errs = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: one outstanding transaction described by the edge it was latched on (tl)
  // and the edge its response was decided on (te); outputs follow from those offsets.
  int cyc = 0, mg = 0, rr = 0, tl = -100, te = -1;
  bit busy = 0, mrd = 0, mterr = 0;
  logic [AW-1:0] ma = '0;
  logic [DW-1:0] md = '0, mrdata = '0;
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      busy = 0; rr = 0; ma = '0; md = '0; mrdata = '0; mterr = 0; tl = -100; te = -1;
    end else if (busy && te >= 0 && cyc == te + 1) begin
      busy = 0;
      rr = (mg + 1) % NR;
    end else if (!busy) begin
      if (req != 0) begin
        for (int i = 0; i < NR; i++)
          if (req[(rr + i) % NR]) begin
            mg = (rr + i) % NR;
            break;
          end
        mrd = req_rd[mg];
        ma = req_addr[mg*AW +: AW];
        md = req_data[mg*DW +: DW];
        busy = 1; tl = cyc; te = -1; mterr = 0;
      end
    end else if (te < 0 && cyc >= tl + 2) begin
      if (ctrl_done) begin
        te = cyc; mterr = 0;
        if (mrd) mrdata = ctrl_rdata;
      end else if (cyc - tl - 2 == TO - 1) begin
        te = cyc; mterr = 1; mrdata = '0;
      end
    end
    #1;
    chk("grant", grant, busy ? (32'd1 << mg) : 32'd0);
    chk("ack", ack, (busy && te == cyc) ? (32'd1 << mg) : 32'd0);
    chk("wr_en", wr_en, busy && cyc == tl + 1 && !mrd);
    chk("rd_en", rd_en, busy && cyc == tl + 1 && mrd);
    chk("timeout_err", timeout_err, busy && te == cyc && mterr);
    chk("addr", addr, ma);
    chk("data", data, md);
    chk("rdata", rdata, mrdata);
  end

  // Controller stand-in: answers each command after a latency, optionally never,
  // and can inject stray done pulses.
  int pend = 0, lat = 5;
  bit auto_en = 0, rand_lat = 0, noise = 0, rd_fixed = 0;
  logic [DW-1:0] rd_val = '0;
  always @(posedge clk) begin
    #1;
    auto_done = 0;
    ctrl_rdata = rd_fixed ? rd_val : DW'($urandom);
    if (!auto_en) pend = 0;
    else if (wr_en || rd_en)
      pend = !rand_lat ? lat : ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(1, 8));
    else if (pend > 0) begin
      pend--;
      if (pend == 0) auto_done = 1;
    end else if (noise && $urandom_range(0, 19) == 0) auto_done = 1;
  end

  task automatic do_reset();
    reset = 0;
    repeat (5) tick();
    reset = 1;
    tick();
  endtask
  task automatic wait_cmd();
    int n = 0;
    while (!(wr_en || rd_en) && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_seen", wr_en || rd_en, 1);
  endtask
  task automatic wait_ack(output logic [NR-1:0] a);
    int n = 0;
    do begin
      tick();
      n++;
    end while (ack == 0 && n < 60);
    chk("ack_seen", ack != 0, 1);
    a = ack;
  endtask

  logic [NR-1:0] a;
  logic [NR-1:0] exp3 [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                              4'b0100, 4'b1000, 4'b0001, 4'b0100};
  int n;
  initial begin
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_addr", addr, 0);
    chk("rst_rdata", rdata, 0);
    // single write
    req[0] = 1; req_rd[0] = 0; req_addr[0 +: AW] = 6'h0D; req_data[0 +: DW] = 8'h9B;
    wait_cmd();
    chk("t1_wr_en", wr_en, 1);
    chk("t1_rd_en", rd_en, 0);
    chk("t1_addr", addr, 6'h0D);
    chk("t1_data", data, 8'h9B);
    req = '0;
    repeat (29) tick();
    man_done = 1;
    tick();
    man_done = 0;
    chk("t1_ack", ack, 4'b0001);
    chk("t1_terr", timeout_err, 0);
    // single read
    do_reset();
    rd_fixed = 1; rd_val = 8'hA5;
    req[1] = 1; req_rd[1] = 1; req_addr[AW +: AW] = 6'h13;
    wait_cmd();
    chk("t2_rd_en", rd_en, 1);
    chk("t2_wr_en", wr_en, 0);
    chk("t2_addr", addr, 6'h13);
    req = '0;
    repeat (3) tick();
    man_done = 1;
    tick();
    man_done = 0;
    chk("t2_ack", ack, 4'b0010);
    chk("t2_rdata", rdata, 8'hA5);
    rd_fixed = 0;
    // round robin, then drop requester 1
    do_reset();
    auto_en = 1; lat = 5; req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      wait_ack(a);
      chk("t3_order", a, exp3[i]);
      if (i == 4) req[1] = 0;
    end
    req = '0;
    repeat (20) tick();
    auto_en = 0;
    // timeout, then done arriving in the final wait cycle
    do_reset();
    req[2] = 1; req_rd[2] = 0;
    wait_cmd();
    req = '0;
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == 0 && n < TO + 10);
    chk("t4_latency", n, TO);
    chk("t4_ack", ack, 4'b0100);
    chk("t4_terr", timeout_err, 1);
    chk("t4_rdata", rdata, 0);
    tick();
    chk("t4_terr_clear", timeout_err, 0);
    req[2] = 1;
    wait_cmd();
    req = '0;
    repeat (TO - 1) tick();
    man_done = 1;
    tick();
    man_done = 0;
    chk("t4b_ack", ack, 4'b0100);
    chk("t4b_terr", timeout_err, 0);
    repeat (3) tick();
    // reset during WAIT
    do_reset();
    req[1] = 1; req_rd[1] = 0;
    wait_cmd();
    req = '0;
    repeat (5) tick();
    reset = 0;
    tick();
    chk("t5_grant", grant, 0);
    chk("t5_ack", ack, 0);
    chk("t5_addr", addr, 0);
    reset = 1;
    repeat (10) tick();
    auto_en = 1; lat = 4; req = 4'b1000;
    wait_ack(a);
    chk("t5_ack3", a, 4'b1000);
    req = '0;
    repeat (3) tick();
    auto_en = 0;
    // stray done in IDLE, request dropped and address changed after latch
    do_reset();
    man_done = 1;
    tick();
    man_done = 0;
    chk("t6_idle_grant", grant, 0);
    req[0] = 1; req_rd[0] = 1; req_addr[0 +: AW] = 6'h2A;
    tick();
    chk("t6_grant", grant, 4'b0001);
    req = '0; req_addr[0 +: AW] = 6'h3F;
    wait_cmd();
    chk("t6_rd_en", rd_en, 1);
    chk("t6_addr", addr, 6'h2A);
    rd_fixed = 1; rd_val = 8'h5C;
    repeat (2) tick();
    man_done = 1;
    tick();
    man_done = 0;
    chk("t6_ack", ack, 4'b0001);
    chk("t6_rdata", rdata, 8'h5C);
    rd_fixed = 0;
    // random traffic with random latency, hangs, stray dones and occasional reset
    do_reset();
    auto_en = 1; rand_lat = 1; noise = 1;
    repeat (4000) begin
      if ($urandom_range(0, 3) == 0) begin
        req = NR'($urandom);
        req_rd = NR'($urandom);
        req_addr = AB'($urandom);
        req_data = $urandom;
      end
      reset = ($urandom_range(0, 399) != 0);
      tick();
    end
    reset = 1; req = '0; noise = 0;
    repeat (TO + 20) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
